adc_serial_capture: RTL and testbench

- Front-end reader for the 4-channel, 16-bit simultaneous-sampling serial ADC: CNV, SCK, and four SDO lanes.
- Generates the conversion strobe and the SCK burst, then deserialises the four SDO lanes into one 64-bit sample word per conversion.
- Runs entirely in the adc_clk domain.
- Feeds the sample-to-DMA packer, which splits each 64-bit word into bytes for the AXI-Stream FIFO path.

---
 rtl/adc_serial_capture.sv | 156 +++++++++++++++
 tb/tb_adc_serial_capture.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_capture.sv
// Serial ADC front-end: drives CNV and a gated SCK burst, then deserialises
// four SDO lanes into one {ch4,ch3,ch2,ch1} sample word per conversion.
module adc_serial_capture #(
  parameter int CNV_HIGH    = 2,
  parameter int CONV_CYCLES = 45,
  parameter int SCK_HALF    = 1,
  parameter int DATA_BITS   = 16
) (
  input  logic                   adc_clk,
  input  logic                   adc_rst_n,
  input  logic                   enable,
  input  logic [31:0]            sample_period,
  output logic                   adc_CNV,
  output logic                   adc_SCK,
  input  logic                   adc_SDO1,
  input  logic                   adc_SDO2,
  input  logic                   adc_SDO3,
  input  logic                   adc_SDO4,
  output logic [4*DATA_BITS-1:0] sample_data,
  output logic                   sample_valid,
  output logic                   busy,
  output logic [31:0]            frame_cnt
);

  localparam int FRAME_LEN = CNV_HIGH + CONV_CYCLES + 2 * DATA_BITS * SCK_HALF + 1;
  localparam int BW        = $clog2(DATA_BITS + 1);

  localparam logic [31:0]   FRAME_LEN_W = 32'(FRAME_LEN);
  localparam logic [31:0]   CNV_LAST    = 32'(CNV_HIGH - 1);
  localparam logic [31:0]   CONV_LAST   = 32'(CONV_CYCLES - 1);
  localparam logic [31:0]   HALF_LAST   = 32'(SCK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CNV   = 3'd1;
  localparam logic [2:0] S_CONV  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;

  logic [2:0]           state, state_nxt;
  logic [31:0]          step_cnt;
  logic                 sck_high;
  logic [BW-1:0]        bit_cnt;
  logic [31:0]          per_cnt;
  logic [31:0]          period_q;
  logic [31:0]          period_target;
  logic [3:0]           sdo_q;
  logic [DATA_BITS-1:0] lane_sr [4];

  logic enter_cnv, enter_shift, half_end, frame_end;

  // Short or zero periods collapse to the natural frame length.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    period_target = FRAME_LEN_W - 32'd1;
    if (period_q > FRAME_LEN_W)
      period_target = period_q - 32'd1;
  end

  assign half_end  = (state == S_SHIFT) && (step_cnt == HALF_LAST);
  assign frame_end = half_end && !sck_high && (bit_cnt == BIT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable) state_nxt = S_CNV;
      S_CNV:   if (step_cnt == CNV_LAST) state_nxt = S_CONV;
      S_CONV:  if (step_cnt == CONV_LAST) state_nxt = S_SHIFT;
      S_SHIFT: if (frame_end) state_nxt = S_DONE;
      // Back-to-back frames leave DONE straight for CNV so CNV repeats every FRAME_LEN.
      S_DONE:  state_nxt = (enable && per_cnt >= period_target) ? S_CNV : S_WAIT;
      S_WAIT: begin
        if (!enable)
          state_nxt = S_IDLE;
        else if (per_cnt >= period_target)
          state_nxt = S_CNV;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign enter_cnv   = (state_nxt == S_CNV) && (state != S_CNV);
  assign enter_shift = (state_nxt == S_SHIFT) && (state != S_SHIFT);

  // Control: state, phase timers and the frame period counter.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      state    <= S_IDLE;
      step_cnt <= '0;
      sck_high <= 1'b0;
      bit_cnt  <= '0;
      per_cnt  <= '0;
      period_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;

      if (state_nxt != state || half_end)
        step_cnt <= '0;
      else
        step_cnt <= step_cnt + 32'd1;

      if (enter_cnv) begin
        per_cnt  <= '0;
        period_q <= sample_period;
      end else if (per_cnt != '1) begin
        per_cnt <= per_cnt + 32'd1;
      end

      if (enter_shift) begin
        sck_high <= 1'b1;
        bit_cnt  <= '0;
      end else if (half_end) begin
        sck_high <= ~sck_high;
        if (!sck_high)
          bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

  // Datapath: lane deserialisers and the delivered sample word.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      // NOTE: the small lane array is reset too, so no X can ever reach sample_data.
      for (int i = 0; i < 4; i++) lane_sr[i] <= '0;
      sdo_q        <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      sdo_q        <= {adc_SDO4, adc_SDO3, adc_SDO2, adc_SDO1};
      sample_valid <= 1'b0;

      // Capture on the last cycle of each SCK high phase, MSB first.
      if (half_end && sck_high) begin
        for (int i = 0; i < 4; i++)
          lane_sr[i] <= {lane_sr[i][DATA_BITS-2:0], sdo_q[i]};
      end

      if (state == S_IDLE && enable)
        frame_cnt <= '0;

      if (frame_end) begin
        sample_data  <= {lane_sr[3], lane_sr[2], lane_sr[1], lane_sr[0]};
        sample_valid <= 1'b1;
        frame_cnt    <= frame_cnt + 32'd1;
      end
    end
  end

  assign adc_CNV = (state == S_CNV);
  assign adc_SCK = (state == S_SHIFT) && sck_high;
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_adc_serial_capture.sv
// Self-checking bench for adc_serial_capture: behavioural ADC model plus
// frame-timing expectations derived arithmetically from the frame layout.
module tb_adc_serial_capture;

  localparam int CNV_HIGH    = 2;
  localparam int CONV_CYCLES = 10;
  localparam int SCK_HALF    = 2;
  localparam int DATA_BITS   = 16;
  localparam int FRAME_LEN   = CNV_HIGH + CONV_CYCLES + 2 * DATA_BITS * SCK_HALF + 1;
  localparam int SCK_START   = CNV_HIGH + CONV_CYCLES;
  localparam int SCK_PER     = 2 * SCK_HALF;

  logic        adc_clk = 1'b0;
  logic        adc_rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] sample_period = 32'd100;
  logic        adc_CNV, adc_SCK;
  logic        adc_SDO1, adc_SDO2, adc_SDO3, adc_SDO4;
  logic [63:0] sample_data;
  logic        sample_valid, busy;
  logic [31:0] frame_cnt;

  adc_serial_capture #(
    .CNV_HIGH(CNV_HIGH), .CONV_CYCLES(CONV_CYCLES),
    .SCK_HALF(SCK_HALF), .DATA_BITS(DATA_BITS)
  ) dut (
    .adc_clk(adc_clk), .adc_rst_n(adc_rst_n), .enable(enable),
    .sample_period(sample_period), .adc_CNV(adc_CNV), .adc_SCK(adc_SCK),
    .adc_SDO1(adc_SDO1), .adc_SDO2(adc_SDO2), .adc_SDO3(adc_SDO3), .adc_SDO4(adc_SDO4),
    .sample_data(sample_data), .sample_valid(sample_valid), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  always #5 adc_clk = ~adc_clk;

  int cyc = 0;
  always @(posedge adc_clk) cyc <= cyc + 1;

  // ADC model: word latched at conversion end, MSB presented first, next bit after each SCK fall.
  logic [63:0] dir_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] next_w;
  logic [15:0] adc_sr [4] = '{default: '0};

  assign adc_SDO1 = adc_sr[0][15];
  assign adc_SDO2 = adc_sr[1][15];
  assign adc_SDO3 = adc_sr[2][15];
  assign adc_SDO4 = adc_sr[3][15];

  always @(negedge adc_CNV) begin
    if (adc_rst_n === 1'b1) begin
      if (dir_q.size() > 0) next_w = dir_q.pop_front();
      else                  next_w = {$urandom, $urandom};
      exp_q.push_back(next_w);
      #1;
      for (int k = 0; k < 4; k++) adc_sr[k] = next_w[16*k +: 16];
    end
  end

  always @(negedge adc_SCK) begin
    if (adc_rst_n === 1'b1) begin
      #1;
      for (int k = 0; k < 4; k++) adc_sr[k] = {adc_sr[k][14:0], 1'b0};
    end
  end

  // Monitor, sampled on the falling clock edge.
  int          cnv_q[$], cnvf_q[$], sck_q[$], vcyc_q[$];
  logic [63:0] vdata_q[$];
  logic [31:0] vfc_q[$];
  int          overlap = 0;
  logic        cnv_prev = 1'b0, sck_prev = 1'b0;

  always @(negedge adc_clk) begin
    if (adc_CNV && !cnv_prev) cnv_q.push_back(cyc);
    if (!adc_CNV && cnv_prev) cnvf_q.push_back(cyc);
    if (adc_SCK && !sck_prev) sck_q.push_back(cyc);
    if (adc_SCK && adc_CNV)   overlap++;
    if (sample_valid) begin
      vcyc_q.push_back(cyc);
      vdata_q.push_back(sample_data);
      vfc_q.push_back(frame_cnt);
    end
    cnv_prev = adc_CNV;
    sck_prev = adc_SCK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cnv_q.delete(); cnvf_q.delete(); sck_q.delete();
    vcyc_q.delete(); vdata_q.delete(); vfc_q.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge adc_clk);
  endtask

  task automatic wait_valids(input int n, input int bound);
    int k = 0;
    while (vcyc_q.size() < n && k < bound) begin @(negedge adc_clk); k++; end
    check("valid_count_wait", 64'(vcyc_q.size()), 64'(n));
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy !== 1'b0 && k < bound) begin @(negedge adc_clk); k++; end
    check("idle_wait", 64'(busy), 64'd0);
  endtask

  // Expected frame i: CNV high CNV_HIGH cycles, SCK rises at CNV+SCK_START+SCK_PER*j,
  // valid at CNV+FRAME_LEN-1 carrying the word the ADC model converted.
  task automatic check_frames(input int first, input int n, input int period_eff, input int fc_first);
    for (int i = first; i < first + n; i++) begin
      int bad = 0;
      if (period_eff > 0 && i > first)
        check("cnv_interval", 64'(cnv_q[i] - cnv_q[i-1]), 64'(period_eff));
      check("cnv_width", 64'(cnvf_q[i] - cnv_q[i]), 64'(CNV_HIGH));
      check("valid_cycle", 64'(vcyc_q[i] - cnv_q[i]), 64'(FRAME_LEN - 1));
      check("sample_data", vdata_q[i], exp_q.pop_front());
      check("frame_cnt", 64'(vfc_q[i]), 64'(fc_first + i - first));
      for (int j = 0; j < DATA_BITS; j++)
        if (sck_q[DATA_BITS*i + j] != cnv_q[i] + SCK_START + SCK_PER*j) bad++;
      check("sck_timing", 64'(bad), 64'd0);
    end
  endtask

  localparam logic [63:0] WORD_A = 64'hAAAA_5555_AAAA_5555;
  localparam logic [63:0] WORD_B = 64'h5555_AAAA_5555_AAAA;

  initial begin
    int p1, p2, k, t0;
    logic [63:0] last_w;

    // Reset state
    cycles(3);
    check("rst_cnv", 64'(adc_CNV), 64'd0);
    check("rst_sck", 64'(adc_SCK), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(sample_valid), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_data", sample_data, 64'd0);
    adc_rst_n = 1'b1;
    cycles(20);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_no_cnv", 64'(cnv_q.size()), 64'd0);

    // Single frame followed by periodic frames at sample_period=100
    clear_mon();
    dir_q.push_back(64'h7FFE_8001_ABCD_1234);
    sample_period = 32'd100;
    enable = 1'b1;
    wait_valids(5, 700);
    enable = 1'b0;
    wait_idle(20);
    cycles(150);
    check("single_data", vdata_q[0], 64'h7FFE_8001_ABCD_1234);
    check("single_first_sck", 64'(sck_q[0] - cnv_q[0]), 64'(SCK_START));
    check("periodic_cnv_count", 64'(cnv_q.size()), 64'd5);
    check("periodic_valid_count", 64'(vcyc_q.size()), 64'd5);
    check("periodic_sck_count", 64'(sck_q.size()), 64'(5 * DATA_BITS));
    check("periodic_cnv_span", 64'(cnv_q[4] - cnv_q[0]), 64'd400);
    last_w = vdata_q[4];
    check_frames(0, 5, 100, 1);
    check("idle_frame_cnt_hold", 64'(frame_cnt), 64'd5);
    check("idle_data_hold", sample_data, last_w);

    // Restart back-to-back with alternating lane patterns
    clear_mon();
    for (int i = 0; i < 2; i++) begin dir_q.push_back(WORD_A); dir_q.push_back(WORD_B); end
    sample_period = 32'd10;
    enable = 1'b1;
    cycles(1);
    check("restart_frame_cnt_clear", 64'(frame_cnt), 64'd0);
    check("restart_cnv", 64'(adc_CNV), 64'd1);
    wait_valids(4, 400);
    check_frames(0, 4, FRAME_LEN, 1);

    // Stop mid-frame: drop enable 30 cycles into frame 5 (random data)
    k = 0;
    while (cnv_q.size() < 5 && k < 100) begin cycles(1); k++; end
    check("stop_frame_started", 64'(cnv_q.size()), 64'd5);
    t0 = cnv_q[4];
    k = 0;
    while (cyc - t0 < 30 && k < 100) begin cycles(1); k++; end
    enable = 1'b0;
    wait_valids(5, 100);
    check_frames(4, 1, 0, 5);
    k = 0;
    while (cyc - t0 < FRAME_LEN && k < 100) begin cycles(1); k++; end
    check("stop_busy_wait", 64'(busy), 64'd1);
    cycles(1);
    check("stop_busy_idle", 64'(busy), 64'd0);
    cycles(150);
    check("stop_no_new_cnv", 64'(cnv_q.size()), 64'd5);
    check("stop_sck_count", 64'(sck_q.size()), 64'(5 * DATA_BITS));

    // Random periods; a mid-frame period change applies from the next frame
    clear_mon();
    p1 = int'($urandom_range(78, 140));
    p2 = int'($urandom_range(78, 140));
    sample_period = 32'(p1);
    enable = 1'b1;
    cycles(20);
    sample_period = 32'(p2);
    wait_valids(3, 600);
    enable = 1'b0;
    wait_idle(20);
    check("rand_interval_1", 64'(cnv_q[1] - cnv_q[0]), 64'(p1));
    check("rand_interval_2", 64'(cnv_q[2] - cnv_q[1]), 64'(p2));
    check("rand_cnv_count", 64'(cnv_q.size()), 64'd3);
    check_frames(0, 3, 0, 1);

    // Reset asserted mid-SHIFT of the second frame
    clear_mon();
    sample_period = 32'd100;
    enable = 1'b1;
    wait_valids(1, 200);
    k = 0;
    while (adc_SCK !== 1'b1 && k < 200) begin cycles(1); k++; end
    check("shift_reached", 64'(adc_SCK), 64'd1);
    @(posedge adc_clk);
    #1 adc_rst_n = 1'b0;
    #1;
    check("midrst_sck", 64'(adc_SCK), 64'd0);
    check("midrst_cnv", 64'(adc_CNV), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(sample_valid), 64'd0);
    check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("midrst_data", sample_data, 64'd0);
    enable = 1'b0;
    exp_q.delete();
    cycles(3);
    adc_rst_n = 1'b1;
    clear_mon();
    cycles(50);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_no_cnv", 64'(cnv_q.size()), 64'd0);
    check("cnv_sck_overlap", 64'(overlap), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
